// File: rtl/mu0_pkg.sv
// Shared constants for the MU0 control unit: opcodes, ALU function codes
// and the controller state encoding.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_B   = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_IDLE  = 3'd1,
        S_FETCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

endpackage

// File: rtl/mu0_mem_timer.sv
// Memory wait counter: counts cycles a request has been pending without an
// acknowledge and flags the last permitted wait cycle.
module mu0_mem_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(MEM_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    // Count pending-request cycles; saturate so an unlimited wait never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // A timeout of zero disables the limit entirely.
    assign expired = (MEM_TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mu0_ctrl.sv
// MU0 control unit. A posedge state register sequences fetch and execute;
// the datapath enables are Mealy outputs decoded from state and inputs so
// the negedge-clocked datapath registers capture them in the same cycle.
//
//   state   | meaning
//   S_RST   | one cycle after reset, clears PC
//   S_IDLE  | waiting for run
//   S_FETCH | reading instruction at PC, loads IR and PC+1 on ack
//   S_EXEC  | executing the opcode held in IR
//   S_HALT  | STP or illegal opcode, sticky until reset
//   S_FAULT | memory access timed out, sticky until reset
module mu0_ctrl
    import mu0_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       acc15,
    input  logic       accz,
    input  logic       mem_ack,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] alufs,
    output logic       accce,
    output logic       pcce,
    output logic       pc_clr,
    output logic       irce,
    output logic       acc_oe,
    output logic       halted,
    output logic       fault
);

    state_t state;
    state_t state_nx;
    logic   req;
    logic   expired;
    logic   timer_inc;
    logic   timer_clr;

    // Counter runs only while a request waits; any other cycle restarts it,
    // so every new access begins counting from zero.
    assign timer_inc = req & ~mem_ack;
    assign timer_clr = ~timer_inc;

    mu0_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expired(expired)
    );

    // Next-state and Mealy output decode.
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        alufs    = ALU_ADD;
        accce    = 1'b0;
        pcce     = 1'b0;
        pc_clr   = 1'b0;
        irce     = 1'b0;
        acc_oe   = 1'b0;
        req      = 1'b0;

        case (state)
            S_RST: begin
                pc_clr   = 1'b1;
                state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                req    = 1'b1;
                if (mem_ack) begin
                    irce     = 1'b1;
                    pcce     = 1'b1;
                    alufs    = ALU_INC;
                    state_nx = S_EXEC;
                end else if (expired) begin
                    state_nx = S_FAULT;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        asel   = 1'b1;
                        mem_rd = 1'b1;
                        req    = 1'b1;
                        if (mem_ack) begin
                            bsel     = 1'b1;
                            accce    = 1'b1;
                            alufs    = (opcode == OP_LDA) ? ALU_B :
                                       (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                            state_nx = run ? S_FETCH : S_IDLE;
                        end else if (expired) begin
                            state_nx = S_FAULT;
                        end
                    end
                    OP_STO: begin
                        asel   = 1'b1;
                        mem_wr = 1'b1;
                        acc_oe = 1'b1;
                        req    = 1'b1;
                        if (mem_ack) begin
                            state_nx = run ? S_FETCH : S_IDLE;
                        end else if (expired) begin
                            state_nx = S_FAULT;
                        end
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        asel     = 1'b1;
                        alufs    = ALU_B;
                        pcce     = (opcode == OP_JMP) ? 1'b1 :
                                   (opcode == OP_JGE) ? ~acc15 : ~accz;
                        state_nx = run ? S_FETCH : S_IDLE;
                    end
                    default: begin
                        state_nx = S_HALT;
                    end
                endcase
            end
            S_HALT, S_FAULT: begin
                state_nx = state;
            end
            default: begin
                state_nx = S_RST;
            end
        endcase

        // Reset wins combinationally so an in-flight request drops in the
        // reset cycle itself; PC is held cleared while reset is asserted.
        if (reset) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            asel   = 1'b0;
            bsel   = 1'b0;
            alufs  = ALU_ADD;
            accce  = 1'b0;
            pcce   = 1'b0;
            irce   = 1'b0;
            acc_oe = 1'b0;
            req    = 1'b0;
            pc_clr = 1'b1;
        end
    end

    // State register with sticky halt/fault flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_RST;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state_nx == S_HALT) || (state_nx == S_FAULT)) halted <= 1'b1;
            if (state_nx == S_FAULT) fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mu0_ctrl.sv
// Scoreboard bench for mu0_ctrl: a stimulus process drives inputs and pushes
// the reference model's expected outputs; a negedge monitor pops and compares.
module tb_mu0_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       acc15 = 1'b0;
    logic       accz = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_rd, mem_wr, asel, bsel, accce, pcce, pc_clr, irce, acc_oe, halted, fault;
    logic [1:0] alufs;

    mu0_ctrl #(.MEM_TIMEOUT(T), .TMR_W(8)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .acc15(acc15),
        .accz(accz), .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .asel(asel), .bsel(bsel), .alufs(alufs), .accce(accce), .pcce(pcce),
        .pc_clr(pc_clr), .irce(irce), .acc_oe(acc_oe), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_rd, mem_wr, asel, bsel;
        logic [1:0] alufs;
        logic       accce, pcce, pc_clr, irce, acc_oe, halted, fault;
    } out_t;

    typedef enum {M_RST, M_IDLE, M_FETCH, M_EXEC, M_HALT, M_FAULT} mphase_t;

    out_t    exp_q[$];
    int      tag_q[$];
    int      checks = 0;
    int      passed = 0;
    int      cyc_no = 0;
    mphase_t ph = M_RST;
    int      wait_n = 0;
    bit      model_valid = 0;

    // Expected outputs for the current cycle from the model phase and inputs.
    function automatic out_t predict();
        out_t o;
        o = '0;
        o.halted = (ph == M_HALT) || (ph == M_FAULT);
        o.fault  = (ph == M_FAULT);
        if (reset) begin
            o.pc_clr = 1'b1;
            return o;
        end
        case (ph)
            M_RST: o.pc_clr = 1'b1;
            M_FETCH: begin
                o.mem_rd = 1'b1;
                if (mem_ack) begin
                    o.irce = 1'b1; o.pcce = 1'b1; o.alufs = 2'b11;
                end
            end
            M_EXEC: begin
                if (opcode <= 4'd3) begin
                    o.asel = 1'b1;
                    if (opcode == 4'd1) begin
                        o.mem_wr = 1'b1; o.acc_oe = 1'b1;
                    end else begin
                        o.mem_rd = 1'b1;
                        if (mem_ack) begin
                            o.bsel = 1'b1; o.accce = 1'b1;
                            o.alufs = (opcode == 4'd0) ? 2'b10 : (opcode == 4'd2) ? 2'b00 : 2'b01;
                        end
                    end
                end else if (opcode <= 4'd6) begin
                    o.asel  = 1'b1;
                    o.alufs = 2'b10;
                    o.pcce  = (opcode == 4'd4) ? 1'b1 : (opcode == 4'd5) ? !acc15 : !accz;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

    // Advance the model by one clock using the inputs held this cycle.
    task automatic model_step();
        bit is_mem;
        if (reset) begin
            ph = M_RST; wait_n = 0; model_valid = 1;
            return;
        end
        if (!model_valid) return;
        case (ph)
            M_RST:  ph = M_IDLE;
            M_IDLE: if (run) ph = M_FETCH;
            M_FETCH, M_EXEC: begin
                is_mem = (ph == M_FETCH) || (opcode <= 4'd3);
                if (!is_mem) begin
                    wait_n = 0;
                    ph = (opcode > 4'd6) ? M_HALT : (run ? M_FETCH : M_IDLE);
                end else if (mem_ack) begin
                    wait_n = 0;
                    ph = (ph == M_FETCH) ? M_EXEC : (run ? M_FETCH : M_IDLE);
                end else if (wait_n == T - 1) begin
                    ph = M_FAULT;
                end else begin
                    wait_n++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit r, input bit rn, input int op, input bit a15, input bit az, input bit ack);
        reset = r; run = rn; opcode = op[3:0]; acc15 = a15; accz = az; mem_ack = ack;
        if (model_valid) begin
            exp_q.push_back(predict());
            tag_q.push_back(cyc_no);
        end
        @(posedge clk);
        model_step();
        cyc_no++;
        #1;
    endtask

    // d wait cycles, then the ack cycle; run only matters when the phase ends.
    task automatic phase(input int op, input int d, input bit rn, input bit a15, input bit az);
        repeat (d) cyc(0, 1, op, a15, az, 0);
        cyc(0, rn, op, a15, az, 1);
    endtask

    out_t mon_e, mon_a;
    int   mon_t;

    // Monitor: compare the DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {mem_rd, mem_wr, asel, bsel, alufs, accce, pcce, pc_clr, irce, acc_oe, halted, fault};
            checks++;
            if (mon_a === mon_e) passed++;
            else $display("FAIL ctrl_outputs cycle %0d: got %b expected %b (rd wr asel bsel alufs accce pcce pc_clr irce acc_oe halted fault)",
                          mon_t, mon_a, mon_e);
        end
    end

    initial begin
        bit r;
        int op;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        phase(0, 1, 1, 0, 0);
        phase(0, 2, 1, 0, 0);
        phase(5, 0, 1, 0, 0); phase(5, 0, 1, 1, 0);
        phase(5, 0, 1, 0, 0); phase(5, 0, 1, 0, 0);
        phase(6, 0, 1, 0, 0); phase(6, 0, 1, 0, 1);
        phase(6, 0, 1, 0, 0); phase(6, 0, 1, 0, 0);
        phase(4, 0, 1, 0, 0); phase(4, 0, 1, 1, 1);
        phase(1, 0, 1, 0, 0); phase(1, 2, 1, 0, 0);
        phase(2, 0, 1, 0, 0); phase(2, 0, 1, 0, 0);
        phase(3, 0, 1, 0, 0); phase(3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        phase(7, 0, 1, 0, 0); phase(7, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        phase(12, 0, 1, 0, 0); phase(12, 0, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
        phase(0, 3, 1, 0, 0); phase(0, 3, 1, 0, 0);
        phase(1, 3, 1, 0, 0); phase(1, 3, 1, 0, 0);
        phase(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 2500; i++) begin
            if ((ph == M_HALT) || (ph == M_FAULT)) r = ($urandom % 3) == 0;
            else r = ($urandom % 150) == 0;
            op = (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 7);
            cyc(r, ($urandom % 8) != 0, op, $urandom % 2, $urandom % 2, $urandom % 2);
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
